// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control FSM: states, instruction fields, datapath selects.
// Branch states exist only when CPU_CTRL_BRANCH_EN is defined.
package cpu_pkg;

    typedef enum logic [4:0] {
        StRst    = 5'd0,
        StIf1    = 5'd1,
        StUpdpc  = 5'd2,
        StDecode = 5'd3,
        StWrImm  = 5'd4,
        StGetA   = 5'd5,
        StGetB   = 5'd6,
        StAlu    = 5'd7,
        StWrC    = 5'd8,
        StAluS   = 5'd9,
        StAddr   = 5'd10,
        StLatch  = 5'd11,
        StMemRd  = 5'd12,
        StPassB  = 5'd13,
        StMemWr  = 5'd14,
        StHalt   = 5'd15
`ifdef CPU_CTRL_BRANCH_EN
        ,
        StBr     = 5'd16,
        StLink   = 5'd17,
        StBrr    = 5'd18
`endif
    } state_e;

    typedef enum logic [1:0] {
        NselRn = 2'd0,
        NselRm = 2'd1,
        NselRd = 2'd2
    } nsel_e;

    typedef enum logic [1:0] {
        VselC      = 2'd0,
        VselSximm8 = 2'd1,
        VselPc     = 2'd2,
        VselMdata  = 2'd3
    } vsel_e;

    typedef enum logic [1:0] {
        PcselReset = 2'd0,
        PcselInc   = 2'd1,
        PcselRel   = 2'd2,
        PcselReg   = 2'd3
    } pcsel_e;

    typedef enum logic [1:0] {
        MemNone  = 2'd0,
        MemRead  = 2'd1,
        MemWrite = 2'd2
    } mem_cmd_e;

    localparam logic [2:0] OpcB    = 3'b001;
    localparam logic [2:0] OpcBl   = 3'b010;
    localparam logic [2:0] OpcLdr  = 3'b011;
    localparam logic [2:0] OpcStr  = 3'b100;
    localparam logic [2:0] OpcAlu  = 3'b101;
    localparam logic [2:0] OpcMov  = 3'b110;
    localparam logic [2:0] OpcHalt = 3'b111;

    localparam logic [1:0] OpMovReg = 2'b00;
    localparam logic [1:0] OpMovImm = 2'b10;
    localparam logic [1:0] OpAdd    = 2'b00;
    localparam logic [1:0] OpCmp    = 2'b01;
    localparam logic [1:0] OpAnd    = 2'b10;
    localparam logic [1:0] OpMvn    = 2'b11;
    localparam logic [1:0] OpBx     = 2'b00;
    localparam logic [1:0] OpBl     = 2'b11;

    localparam logic [2:0] CondAl = 3'b000;
    localparam logic [2:0] CondEq = 3'b001;
    localparam logic [2:0] CondNe = 3'b010;
    localparam logic [2:0] CondLt = 3'b011;
    localparam logic [2:0] CondLe = 3'b100;

    typedef struct packed {
        nsel_e    nsel;
        vsel_e    vsel;
        logic     loada;
        logic     loadb;
        logic     write;
        logic     asel;
        logic     bsel;
        logic     loads;
        logic     loadc;
        logic     loadpc;
        pcsel_e   pcsel;
        logic     load_addr;
        logic     msel;
        mem_cmd_e mem_cmd;
        logic     halted;
    } ctrl_t;

    localparam ctrl_t CtrlIdle = '{
        nsel: NselRn, vsel: VselC, loada: 1'b0, loadb: 1'b0, write: 1'b0, asel: 1'b0,
        bsel: 1'b0, loads: 1'b0, loadc: 1'b0, loadpc: 1'b0, pcsel: PcselReset,
        load_addr: 1'b0, msel: 1'b0, mem_cmd: MemNone, halted: 1'b0
    };

    localparam ctrl_t CtrlReset = '{
        nsel: NselRn, vsel: VselC, loada: 1'b0, loadb: 1'b0, write: 1'b0, asel: 1'b0,
        bsel: 1'b0, loads: 1'b0, loadc: 1'b0, loadpc: 1'b1, pcsel: PcselReset,
        load_addr: 1'b0, msel: 1'b0, mem_cmd: MemNone, halted: 1'b0
    };

    // Moore control word for a state; GET_B and ALU vary with the instruction in the IR.
    function automatic ctrl_t ctrl_for_state(input state_e s, input logic [2:0] opcode,
                                             input logic [1:0] op);
        ctrl_t c;
        c = CtrlIdle;
        case (s)
            StRst:    begin c.loadpc = 1'b1; c.pcsel = PcselReset; end
            StIf1:    c.mem_cmd = MemRead;
            StUpdpc:  begin c.loadpc = 1'b1; c.pcsel = PcselInc; end
            StWrImm:  begin c.nsel = NselRn; c.vsel = VselSximm8; c.write = 1'b1; end
            StGetA:   begin c.nsel = NselRn; c.loada = 1'b1; end
            StGetB:   begin
                c.nsel  = (opcode == OpcStr || opcode == OpcBl) ? NselRd : NselRm;
                c.loadb = 1'b1;
            end
            StAlu:    begin
                c.asel  = (opcode == OpcMov) || (opcode == OpcAlu && op == OpMvn);
                c.loadc = 1'b1;
            end
            StWrC:    begin c.nsel = NselRd; c.vsel = VselC; c.write = 1'b1; end
            StAluS:   c.loads = 1'b1;
            StAddr:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
            StLatch:  c.load_addr = 1'b1;
            StMemRd:  begin
                c.msel = 1'b1; c.mem_cmd = MemRead; c.nsel = NselRd; c.vsel = VselMdata;
            end
            StPassB:  begin c.asel = 1'b1; c.loadc = 1'b1; end
            StMemWr:  begin c.msel = 1'b1; c.mem_cmd = MemWrite; end
            StHalt:   c.halted = 1'b1;
`ifdef CPU_CTRL_BRANCH_EN
            StBr:     begin c.loadpc = 1'b1; c.pcsel = PcselRel; end
            StLink:   begin c.nsel = NselRn; c.vsel = VselPc; c.write = 1'b1; end
            StBrr:    begin c.loadpc = 1'b1; c.pcsel = PcselReg; end
`endif
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction/status inputs and datapath/memory controls between the CPU controller and datapath.
interface cpu_ctrl_fsm_if;
    import cpu_pkg::*;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic [2:0] status;
    logic       mem_ready;

    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       loads;
    logic       loadc;
    logic       loadir;
    logic       loadpc;
    logic [1:0] pcsel;
    logic       load_addr;
    logic       msel;
    logic [1:0] mem_cmd;
    logic       halted;
    logic       fault;
    logic [4:0] state;

    modport master (
        input  opcode, op, cond, status, mem_ready,
        output nsel, vsel, loada, loadb, write, asel, bsel, loads, loadc,
        output loadir, loadpc, pcsel, load_addr, msel, mem_cmd, halted, fault, state
    );

    modport slave (
        output opcode, op, cond, status, mem_ready,
        input  nsel, vsel, loada, loadb, write, asel, bsel, loads, loadc,
        input  loadir, loadpc, pcsel, load_addr, msel, mem_cmd, halted, fault, state
    );

endinterface

// File: rtl/cpu_cond_eval.sv
// Branch condition evaluation from the {N,V,Z} status register.
module cpu_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [2:0] i_status,
    output logic       o_taken
);

    logic w_n;
    logic w_v;
    logic w_z;
    logic w_lt;

    assign w_n  = i_status[2];
    assign w_v  = i_status[1];
    assign w_z  = i_status[0];
    assign w_lt = w_n ^ w_v;

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            CondAl:  o_taken = 1'b1;
            CondEq:  o_taken = w_z;
            CondNe:  o_taken = ~w_z;
            CondLt:  o_taken = w_lt;
            CondLe:  o_taken = w_lt | w_z;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU controller: fetch/decode/execute sequencing with memory wait timeout.
// Branch support (B, BL, BX) is built only when CPU_CTRL_BRANCH_EN is defined.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input logic            clk,
    input logic            reset,
    cpu_ctrl_fsm_if.master io_bus
);

    if (MEM_WAIT_MAX == 0 || MEM_WAIT_MAX > 255) begin : g_bad_param
        $error("MEM_WAIT_MAX must be in 1..255");
    end

    localparam logic [7:0] WaitLast = 8'(MEM_WAIT_MAX - 1);

    state_e     r_state;
    state_e     w_next_state;
    ctrl_t      r_ctrl;
    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic       w_mem_state;
    logic       w_stall;
    logic       w_wait_hit;
    logic       w_cond_true;

    cpu_cond_eval u_cond_eval (
        .i_cond   (io_bus.cond),
        .i_status (io_bus.status),
        .o_taken  (w_cond_true)
    );

`ifndef CPU_CTRL_BRANCH_EN
    logic w_unused_cond;
    assign w_unused_cond = w_cond_true;
`endif

    assign w_mem_state = (r_state == StIf1) || (r_state == StMemRd) || (r_state == StMemWr);
    assign w_stall     = w_mem_state && !io_bus.mem_ready;
    assign w_wait_hit  = w_stall && (r_wait_cnt == WaitLast);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StRst:    w_next_state = StIf1;
            StIf1:    if (io_bus.mem_ready) w_next_state = StUpdpc;
            StUpdpc:  w_next_state = StDecode;
            StDecode: begin
                case (io_bus.opcode)
                    OpcMov: begin
                        if (io_bus.op == OpMovImm)      w_next_state = StWrImm;
                        else if (io_bus.op == OpMovReg) w_next_state = StGetB;
                        else                            w_next_state = StIf1;
                    end
                    OpcAlu:         w_next_state = (io_bus.op == OpMvn) ? StGetB : StGetA;
                    OpcLdr, OpcStr: w_next_state = StGetA;
                    OpcHalt:        w_next_state = StHalt;
`ifdef CPU_CTRL_BRANCH_EN
                    OpcB:           w_next_state = w_cond_true ? StBr : StIf1;
                    OpcBl: begin
                        if (io_bus.op == OpBl)      w_next_state = StLink;
                        else if (io_bus.op == OpBx) w_next_state = StGetB;
                        else                        w_next_state = StIf1;
                    end
`endif
                    default:        w_next_state = StIf1;
                endcase
            end
            StWrImm:  w_next_state = StIf1;
            StGetA:   w_next_state = (io_bus.opcode == OpcLdr || io_bus.opcode == OpcStr)
                                     ? StAddr : StGetB;
            StGetB: begin
                if (io_bus.opcode == OpcStr || io_bus.opcode == OpcBl) begin
                    w_next_state = StPassB;
                end else if (io_bus.opcode == OpcAlu && io_bus.op == OpCmp) begin
                    w_next_state = StAluS;
                end else begin
                    w_next_state = StAlu;
                end
            end
            StAlu:    w_next_state = StWrC;
            StWrC:    w_next_state = StIf1;
            StAluS:   w_next_state = StIf1;
            StAddr:   w_next_state = StLatch;
            StLatch:  w_next_state = (io_bus.opcode == OpcStr) ? StGetB : StMemRd;
            StMemRd:  if (io_bus.mem_ready) w_next_state = StIf1;
`ifdef CPU_CTRL_BRANCH_EN
            StPassB:  w_next_state = (io_bus.opcode == OpcStr) ? StMemWr : StBrr;
            StBr:     w_next_state = StIf1;
            StLink:   w_next_state = StBr;
            StBrr:    w_next_state = StIf1;
`else
            StPassB:  w_next_state = StMemWr;
`endif
            StMemWr:  if (io_bus.mem_ready) w_next_state = StIf1;
            StHalt:   w_next_state = StHalt;
            default:  w_next_state = StRst;
        endcase
        // A memory timeout overrides whatever the state would otherwise do.
        if (w_wait_hit) w_next_state = StHalt;
    end

    // Control word is registered from the next state so it lines up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StRst;
            r_ctrl     <= CtrlReset;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_for_state(w_next_state, io_bus.opcode, io_bus.op);
            r_fault <= r_fault | w_wait_hit;
            if (w_next_state != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_stall) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    assign io_bus.nsel      = r_ctrl.nsel;
    assign io_bus.vsel      = r_ctrl.vsel;
    assign io_bus.loada     = r_ctrl.loada;
    assign io_bus.loadb     = r_ctrl.loadb;
    assign io_bus.write     = r_ctrl.write | ((r_state == StMemRd) & io_bus.mem_ready);
    assign io_bus.asel      = r_ctrl.asel;
    assign io_bus.bsel      = r_ctrl.bsel;
    assign io_bus.loads     = r_ctrl.loads;
    assign io_bus.loadc     = r_ctrl.loadc;
    assign io_bus.loadir    = (r_state == StIf1) & io_bus.mem_ready;
    assign io_bus.loadpc    = r_ctrl.loadpc;
    assign io_bus.pcsel     = r_ctrl.pcsel;
    assign io_bus.load_addr = r_ctrl.load_addr;
    assign io_bus.msel      = r_ctrl.msel;
    assign io_bus.mem_cmd   = r_ctrl.mem_cmd;
    assign io_bus.halted    = r_ctrl.halted;
    assign io_bus.fault     = r_fault;
    assign io_bus.state     = r_state;

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum number of cycles a memory request may wait for mem_ready before a fault is raised; the legal range is 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have inputs opcode[2:0], op[1:0] and cond[2:0]: decoded fields of the instruction register.
REQ-005 SHALL have input status[2:0], ordered {N,V,Z}: the datapath status register.
REQ-006 SHALL have input mem_ready, 1 bit: memory handshake completion.
REQ-007 SHALL have outputs nsel[1:0], vsel[1:0], loada, loadb, write, asel, bsel, loads, loadc: datapath controls.
REQ-008 SHALL have outputs loadir, loadpc, pcsel[1:0], load_addr, msel and mem_cmd[1:0]: fetch, PC and memory controls.
REQ-009 SHALL have outputs halted, fault and state[4:0]: status and debug.

Function
REQ-010 SHALL implement a Moore FSM; the only Mealy outputs are loadir, write in MEM_RD, and state exit, all qualified by mem_ready.
REQ-011 SHALL place the FSM in RST on reset assertion, with loadpc=1, pcsel=RESET, and every other output 0.
REQ-012 SHALL move from RST to IF1 on the first clk edge after reset deasserts.
REQ-013 IF1 SHALL drive msel=0 and mem_cmd=READ, hold both until mem_ready=1, and assert loadir=mem_ready.
REQ-014 SHALL sequence IF1 (ready) -> UPDPC (loadpc=1, pcsel=INC) -> DECODE.
REQ-015 SHALL decode MOV imm (110/10) as WR_IMM (nsel=RN, vsel=SXIMM8, write=1) -> IF1; this is 4 cycles at zero wait.
REQ-016 SHALL decode MOV reg (110/00) as GET_B (nsel=RM, loadb=1) -> ALU (asel=1, loadc=1) -> WR_C (nsel=RD, vsel=C, write=1) -> IF1.
REQ-017 SHALL decode ALU ADD/AND (101/00, 101/10) as GET_A (nsel=RN, loada=1) -> GET_B -> ALU (asel=0, bsel=0, loadc=1) -> WR_C; ADD is 7 cycles at zero wait.
REQ-018 SHALL decode ALU CMP (101/01) as GET_A -> GET_B -> ALU_S (loads=1, loadc=0) -> IF1, with no register write.
REQ-019 SHALL decode ALU MVN (101/11) with the same path as MOV reg.
REQ-020 SHALL decode LDR (011) as GET_A -> ADDR (bsel=1, loadc=1) -> LATCH (load_addr=1) -> MEM_RD (msel=1, mem_cmd=READ, nsel=RD, vsel=MDATA, write=mem_ready) -> IF1.
REQ-021 SHALL decode STR (100) as GET_A -> ADDR -> LATCH -> GET_B (nsel=RD) -> PASS_B (asel=1, loadc=1) -> MEM_WR (msel=1, mem_cmd=WRITE) -> IF1 on mem_ready.
REQ-022 SHALL decode HALT (111) as HALT, with halted=1 and no exit except reset.
REQ-023 SHALL count cycles in which mem_ready=0 in any memory state; on reaching MEM_WAIT_MAX it SHALL go to HALT with fault=1 sticky; the count clears on state exit.
REQ-024 SHALL treat any undefined opcode/op combination as a NOP (DECODE -> IF1).
REQ-025 SHALL not alter mem_cmd, msel or address controls while waiting for mem_ready.

Reset
REQ-026 SHALL return asynchronously to RST from any state, including mid-wait, with mem_cmd=NONE, fault=0 and halted=0.

Configuration
REQ-027 SHALL gate branch support with macro CPU_CTRL_BRANCH_EN.
REQ-028 With CPU_CTRL_BRANCH_EN defined, SHALL decode B (001) from DECODE: when cond is true, go to BR (loadpc=1, pcsel=REL), otherwise go to IF1.
REQ-029 With CPU_CTRL_BRANCH_EN defined, SHALL evaluate cond as 000=always, 001=Z, 010=!Z, 011=N!=V, 100=(N!=V)|Z, and treat all other values as false.
REQ-030 With CPU_CTRL_BRANCH_EN defined, SHALL decode BL (010/11) as LINK (nsel=RN, vsel=PC, write=1) -> BR.
REQ-031 With CPU_CTRL_BRANCH_EN defined, SHALL decode BX (010/00) as GET_B (nsel=RD) -> PASS_B -> BRR (loadpc=1, pcsel=REG).
REQ-032 Without CPU_CTRL_BRANCH_EN, opcodes 001 and 010 SHALL be NOPs and no branch states SHALL exist.

Structure
REQ-033 SHALL take the state encoding, opcode/op/cond codes, NSEL, VSEL, PCSEL and MEM_CMD enums from shared package cpu_pkg.
REQ-034 SHALL instantiate one sub-module, cpu_cond_eval, implementing the combinational status/cond evaluation.

Verification
REQ-035 Reset released with mem_ready=1 and IR=MOV R0,#5 SHALL give the sequence RST,IF1,UPDPC,DECODE,WR_IMM,IF1, with write=1 for one cycle.
REQ-036 ADD R2,R1,R0 with mem_ready=1 SHALL give 7 cycles IF1..WR_C, with loada, loadb and loadc each high for exactly 1 cycle.
REQ-037 LDR with mem_ready held low 3 cycles in MEM_RD SHALL keep msel=1 and mem_cmd=READ stable and pulse write once on the ready cycle.
REQ-038 STR with mem_ready never asserted SHALL reach HALT with fault=1 after 15 wait cycles; reset then clears fault.
REQ-039 With CPU_CTRL_BRANCH_EN, status={0,0,1} and BEQ SHALL go to BR with pcsel=REL, while status Z=0 SHALL go to IF1; without the macro, opcode 001 SHALL give DECODE->IF1.
REQ-040 Reset asserted during the MEM_WR wait SHALL immediately give mem_cmd=NONE and state=RST.
